c_writeback: RTL and testbench

//  Requantize-and-store stage directly upstream of the C result SRAM (1024 x 8b).

---
 rtl/c_writeback_if.sv | 20 ++
 rtl/c_writeback.sv | 114 +++++++++++
 tb/tb_c_writeback.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/c_writeback_if.sv
// Handshake bundles for the writeback stage: the accumulator stream in and the SRAM write port out.
// master drives the payload; slave returns ready (stream) or consumes the bus (SRAM).
interface acc_stream_if #(parameter int W = 32);
    logic         valid;
    logic [W-1:0] data;
    logic         ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

interface sram_wr_if #(parameter int AW = 10, parameter int DW = 8);
    logic          ce;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;

    modport master (output ce, output we, output addr, output din);
    modport slave  (input ce, input we, input addr, input din);
endinterface

// File: rtl/c_writeback.sv
// Requantizes signed accumulators to int8 and writes them to consecutive SRAM addresses.
// One-cycle write latency after each accept; ready is held high for the whole RUN phase.
module c_writeback #(
    parameter int ACC_W   = 32,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int SHIFT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [ADDR_W:0]     count_i,
    input  logic [SHIFT_W-1:0]  shift_i,
    acc_stream_if.slave         acc,
    sram_wr_if.master           sram,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W:0]     sat_cnt_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic signed [ACC_W:0] Q_MAX =
        {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] Q_MIN = ~Q_MAX;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    base_q, idx_q, addr_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic [ADDR_W:0]      remaining_q, sat_cnt_q;
    logic [DATA_W-1:0]    din_q;
    logic                 ce_q;
    logic                 accept;

    logic signed [ACC_W:0] acc_ext, rnd, sum, r;
    logic [DATA_W-1:0]     q;
    logic                  clip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (count_i == '0) ? DONE : RUN;
            RUN:     if (accept && remaining_q == (ADDR_W+1)'(1)) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc.ready = (state_q == RUN);
        busy_o    = (state_q == RUN) || (state_q == DRAIN);
        done_o    = (state_q == DONE);
    end

    assign accept = acc.valid && acc.ready;

    // One extra bit of headroom so the rounding bias cannot overflow at shift=31.
    always_comb begin
        acc_ext = {acc.data[ACC_W-1], acc.data};
        rnd     = (shift_q == '0) ? '0 : ((ACC_W+1)'(1) << (shift_q - SHIFT_W'(1)));
        sum     = acc_ext + rnd;
        r       = sum >>> shift_q;
        clip    = 1'b0;
        q       = r[DATA_W-1:0];
        if (r > Q_MAX) begin
            q    = Q_MAX[DATA_W-1:0];
            clip = 1'b1;
        end else if (r < Q_MIN) begin
            q    = Q_MIN[DATA_W-1:0];
            clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            shift_q     <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            sat_cnt_q   <= '0;
            ce_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            ce_q <= accept;
            if (state_q == IDLE && start_i) begin
                base_q      <= base_addr_i;
                shift_q     <= shift_i;
                remaining_q <= count_i;
                idx_q       <= '0;
                sat_cnt_q   <= '0;
            end
            if (accept) begin
                addr_q      <= base_q + idx_q;
                din_q       <= q;
                idx_q       <= idx_q + ADDR_W'(1);
                remaining_q <= remaining_q - (ADDR_W+1)'(1);
                if (clip) sat_cnt_q <= sat_cnt_q + (ADDR_W+1)'(1);
            end
        end
    end

    assign sram.ce   = ce_q;
    assign sram.we   = ce_q;
    assign sram.addr = addr_q;
    assign sram.din  = din_q;
    assign sat_cnt_o = sat_cnt_q;
endmodule

// File: tb/tb_c_writeback.sv
// Bench for c_writeback: table vectors, hand-timed sequences and a randomized job against a reference model.
module tb_c_writeback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [9:0]  base_addr_i;
    logic [10:0] count_i;
    logic [4:0]  shift_i;
    logic        busy_o, done_o;
    logic [10:0] sat_cnt_o;

    acc_stream_if #(.W(32))          acc_if ();
    sram_wr_if    #(.AW(10), .DW(8)) sram_if ();

    c_writeback dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .count_i(count_i), .shift_i(shift_i), .acc(acc_if), .sram(sram_if),
        .busy_o(busy_o), .done_o(done_o), .sat_cnt_o(sat_cnt_o)
    );

    always #5 clk = ~clk;

    // sram_C model plus write/done bookkeeping
    logic [7:0] mem  [1024];
    int         hits [1024];
    int         wr_cnt = 0, done_cnt = 0;
    logic       clr_mem;

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i]  <= 8'h5A;
                hits[i] <= 0;
            end
        end else if (sram_if.ce && sram_if.we) begin
            mem[sram_if.addr]  <= sram_if.din;
            hits[sram_if.addr] <= hits[sram_if.addr] + 1;
            wr_cnt             <= wr_cnt + 1;
        end
        if (done_o) done_cnt <= done_cnt + 1;
    end

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference requantizer: 64-bit arithmetic, round half up, clamp to int8.
    function automatic logic [7:0] ref_q(input logic [31:0] a, input int sh, output bit clip);
        longint v;
        v = longint'(signed'(a));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        clip = 1'b0;
        if (v > 127)  begin clip = 1'b1; return 8'h7F; end
        if (v < -128) begin clip = 1'b1; return 8'h80; end
        return 8'(v);
    endfunction

    task automatic clear_mem();
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
    endtask

    task automatic start_job(input int b, input int c, input int s);
        start_i     = 1'b1;
        base_addr_i = 10'(b);
        count_i     = 11'(c);
        shift_i     = 5'(s);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Present one result; returns at the negedge following the accepting edge.
    task automatic send(input logic [31:0] a);
        int waited = 0;
        acc_if.valid = 1'b1;
        acc_if.data  = a;
        while (!acc_if.ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!acc_if.ready) chk("send_timeout", 0, 1);
        else @(negedge clk);
        acc_if.valid = 1'b0;
    endtask

    task automatic wait_done();
        int waited = 0;
        while (!done_o && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        chk("done_seen", done_o, 1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] acc;
        int          sh;
        logic [7:0]  q;
        int          sat;
    } vec_t;

    vec_t vt[16];
    int   wr0, dn0, bad, base, sats;
    bit   clip;
    logic [7:0]  exp_mem [1024];
    logic [31:0] a;

    initial begin
        vt[0]  = '{32'd5,          0, 8'h05, 0};
        vt[1]  = '{-32'sd3,        0, 8'hFD, 0};
        vt[2]  = '{32'd127,        0, 8'h7F, 0};
        vt[3]  = '{-32'sd128,      0, 8'h80, 0};
        vt[4]  = '{32'd128,        0, 8'h7F, 1};
        vt[5]  = '{-32'sd129,      0, 8'h80, 1};
        vt[6]  = '{32'd24,         4, 8'h02, 0};
        vt[7]  = '{32'd23,         4, 8'h01, 0};
        vt[8]  = '{-32'sd24,       4, 8'hFF, 0};
        vt[9]  = '{-32'sd25,       4, 8'hFE, 0};
        vt[10] = '{32'd4096,       4, 8'h7F, 1};
        vt[11] = '{-32'sd4096,     4, 8'h80, 1};
        vt[12] = '{32'h7FFF_FFFF, 31, 8'h01, 0};
        vt[13] = '{32'h8000_0000, 31, 8'hFF, 0};
        vt[14] = '{-32'sd8,        4, 8'h00, 0};
        vt[15] = '{32'd8,          4, 8'h01, 0};

        rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; count_i = '0; shift_i = '0;
        acc_if.valid = 1'b0; acc_if.data = '0; clr_mem = 1'b1;
        repeat (3) @(negedge clk);
        clr_mem = 1'b0;
        chk("rst_ready", acc_if.ready, 0);
        chk("rst_ce",    sram_if.ce,   0);
        chk("rst_busy",  busy_o,       0);
        chk("rst_done",  done_o,       0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a job
        start_job(100, 8, 0);
        send(32'd300); send(32'd6);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", acc_if.ready, 0);
        chk("midrst_we",    sram_if.we,   0);
        chk("midrst_addr",  sram_if.addr, 0);
        chk("midrst_din",   sram_if.din,  0);
        chk("midrst_busy",  busy_o,       0);
        chk("midrst_sat",   sat_cnt_o,    0);
        rst_n = 1'b1;
        wr0 = wr_cnt;
        repeat (12) @(negedge clk);
        chk("midrst_no_done",   done_cnt, 0);
        chk("midrst_no_writes", wr_cnt,   wr0);
        chk("midrst_untouched", mem[102], 8'h5A);

        // Back-to-back basic job with exact done timing
        clear_mem();
        wr0 = wr_cnt; dn0 = done_cnt;
        start_job(0, 4, 0);
        chk("run_busy", busy_o, 1);
        send(32'd5);
        chk("w0_ce", sram_if.ce, 1); chk("w0_addr", sram_if.addr, 0); chk("w0_din", sram_if.din, 8'h05);
        send(-32'sd3); send(32'd127); send(-32'sd128);
        chk("drain_ce", sram_if.ce, 1);   chk("drain_addr", sram_if.addr, 3);
        chk("drain_din", sram_if.din, 8'h80);
        chk("drain_ready", acc_if.ready, 0); chk("drain_busy", busy_o, 1); chk("drain_done", done_o, 0);
        @(negedge clk);
        chk("done_hi", done_o, 1); chk("done_busy", busy_o, 0);
        chk("done_ce", sram_if.ce, 0); chk("done_addr_hold", sram_if.addr, 3);
        @(negedge clk);
        chk("done_pulse_end", done_o, 0);
        chk("b2b_m0", mem[0], 8'h05); chk("b2b_m1", mem[1], 8'hFD);
        chk("b2b_m2", mem[2], 8'h7F); chk("b2b_m3", mem[3], 8'h80);
        chk("b2b_sat", sat_cnt_o, 0);
        chk("b2b_writes", wr_cnt - wr0, 4);
        chk("b2b_dones", done_cnt - dn0, 1);

        // Table vectors, one single-result job each
        for (int i = 0; i < 16; i++) begin
            start_job(200 + i, 1, vt[i].sh);
            send(vt[i].acc);
            wait_done();
            chk($sformatf("vec%0d_q", i),   mem[200 + i], vt[i].q);
            chk($sformatf("vec%0d_sat", i), sat_cnt_o,    vt[i].sat);
        end

        // shift=4 multi-result job with two clips
        start_job(300, 6, 4);
        send(32'd24); send(32'd23); send(-32'sd24); send(-32'sd25); send(32'd4096); send(-32'sd4096);
        wait_done();
        chk("sh4_sat", sat_cnt_o, 2);
        chk("sh4_m300", mem[300], 8'h02); chk("sh4_m305", mem[305], 8'h80);

        // Address wrap
        clear_mem();
        start_job(1022, 4, 0);
        for (int i = 1; i <= 4; i++) send(32'(i));
        wait_done();
        chk("wrap_1022", mem[1022], 8'h01); chk("wrap_1023", mem[1023], 8'h02);
        chk("wrap_0", mem[0], 8'h03); chk("wrap_1", mem[1], 8'h04);
        chk("wrap_2_untouched", mem[2], 8'h5A);

        // Random job with ~50% valid duty
        clear_mem();
        wr0 = wr_cnt; dn0 = done_cnt;
        base = int'($urandom_range(0, 1023));
        shift_i = 5'($urandom_range(0, 10));
        start_job(base, 1000, int'(shift_i));
        sats = 0;
        for (int i = 0; i < 1000; i++) begin
            while ($urandom_range(0, 1) == 0) @(negedge clk);
            case ($urandom_range(0, 2))
                0:       a = $urandom();
                1:       a = 32'((int'($urandom_range(0, 600)) - 300) <<< shift_i);
                default: a = 32'(int'($urandom_range(0, 4000)) - 2000);
            endcase
            exp_mem[(base + i) % 1024] = ref_q(a, int'(shift_i), clip);
            if (clip) sats++;
            send(a);
        end
        wait_done();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 1000; i++)
            chk($sformatf("rnd_addr%0d", (base + i) % 1024), mem[(base + i) % 1024], exp_mem[(base + i) % 1024]);
        chk("rnd_sat", sat_cnt_o, sats);
        chk("rnd_writes", wr_cnt - wr0, 1000);
        chk("rnd_dones", done_cnt - dn0, 1);

        // Full 1024-entry job: every address exactly once
        clear_mem();
        wr0 = wr_cnt;
        start_job(512, 1024, 0);
        for (int i = 0; i < 1024; i++) send(32'(i - 512));
        wait_done();
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (hits[(512 + i) % 1024] != 1) bad++;
            if (mem[(512 + i) % 1024] !== ref_q(32'(i - 512), 0, clip)) bad++;
        end
        chk("full_bad_entries", bad, 0);
        chk("full_writes", wr_cnt - wr0, 1024);

        // count=0 job, with junk valid held through IDLE/DONE
        wr0 = wr_cnt;
        acc_if.valid = 1'b1; acc_if.data = 32'd77;
        start_job(50, 0, 0);
        chk("zero_done", done_o, 1); chk("zero_busy", busy_o, 0);
        @(negedge clk);
        chk("zero_done_end", done_o, 0);
        repeat (3) @(negedge clk);
        acc_if.valid = 1'b0;
        chk("zero_no_writes", wr_cnt - wr0, 0);

        // start while busy is ignored
        clear_mem();
        wr0 = wr_cnt;
        start_job(10, 2, 0);
        start_job(500, 5, 3);
        send(32'd7); send(32'd9);
        wait_done();
        chk("busy_start_m10", mem[10], 8'h07); chk("busy_start_m11", mem[11], 8'h09);
        chk("busy_start_m500", hits[500], 0);
        chk("busy_start_writes", wr_cnt - wr0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
